temp_sense_seq: RTL and testbench

TEMP_SENSE_SEQ -- requirements
Module: temp_sense_seq

---
 rtl/temp_sense_seq.sv | 191 +++++++++++++++++++
 tb/tb_temp_sense_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sense_seq.sv
// rtl/temp_sense_seq.sv - temperature sensor conversion sequencer with averaging and timeout
//
// Sequences one temperature conversion: warms up the sensor, drops the first
// (partial) measurement, averages 2^AVG_LOG2 measurement codes and presents
// the truncated mean. Continuous mode chains conversions without re-settling.
//
// Ports:
//   clk           in   rising-edge clock
//   reset_n       in   synchronous active-low reset
//   start         in   one-cycle conversion request (honoured in IDLE only)
//   cont          in   continuous mode, sampled in DONE
//   abort         in   cancel the conversion in progress
//   meas_valid    in   one-cycle pulse: meas_code is new
//   meas_code     in   measured pulse duration [CODE_W]
//   sensor_en     out  sensor oscillator / measurement block enable
//   busy          out  high in every state except IDLE
//   result        out  averaged code [CODE_W], held until next result_valid
//   result_valid  out  one-cycle strobe: result updated
//   timeout_err   out  sticky timeout flag, cleared by the next accepted start

module temp_sense_seq #(
    parameter int CODE_W         = 12,
    parameter int AVG_LOG2       = 2,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic              meas_valid,
    input  logic [CODE_W-1:0] meas_code,
    output logic              sensor_en,
    output logic              busy,
    output logic [CODE_W-1:0] result,
    output logic              result_valid,
    output logic              timeout_err
);

    // Accumulator holds the sum of 2^AVG_LOG2 codes, so it can never overflow.
    localparam int ACC_W = CODE_W + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SMP_W-1:0] LAST_SMP    = SMP_W'((1 << AVG_LOG2) - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        DISCARD,
        ACCUM,
        DONE
    } state_t;

    state_t            state_q;
    logic [SET_W-1:0]  settle_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [SMP_W-1:0]  smp_cnt_q;
    logic [ACC_W-1:0]  acc_q;
    logic              sensor_en_q;
    logic              busy_q;
    logic [CODE_W-1:0] result_q;
    logic              result_valid_q;
    logic              timeout_err_q;

    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  avg_d;

    always_comb begin
        acc_d = acc_q + ACC_W'(meas_code);
        avg_d = acc_d >> AVG_LOG2;
    end

    // The timeout counter expires at the end of its TIMEOUT_CYCLES-th idle
    // cycle; a meas_valid in that same cycle wins because it is tested first.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            settle_cnt_q   <= '0;
            tmo_cnt_q      <= '0;
            smp_cnt_q      <= '0;
            acc_q          <= '0;
            sensor_en_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (abort) begin
                // Also covers abort+start in IDLE: we simply stay idle.
                state_q     <= IDLE;
                sensor_en_q <= 1'b0;
                busy_q      <= 1'b0;
                tmo_cnt_q   <= '0;
                smp_cnt_q   <= '0;
                acc_q       <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q       <= SETTLE;
                            sensor_en_q   <= 1'b1;
                            busy_q        <= 1'b1;
                            timeout_err_q <= 1'b0;
                            settle_cnt_q  <= SETTLE_LOAD;
                            smp_cnt_q     <= '0;
                            acc_q         <= '0;
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt_q == '0) begin
                            state_q   <= DISCARD;
                            tmo_cnt_q <= '0;
                        end else begin
                            settle_cnt_q <= settle_cnt_q - 1'b1;
                        end
                    end
                    DISCARD: begin
                        if (meas_valid) begin
                            state_q   <= ACCUM;
                            tmo_cnt_q <= '0;
                        end else if (tmo_cnt_q == TMO_LAST) begin
                            state_q       <= IDLE;
                            sensor_en_q   <= 1'b0;
                            busy_q        <= 1'b0;
                            timeout_err_q <= 1'b1;
                            tmo_cnt_q     <= '0;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
                    end
                    ACCUM: begin
                        if (meas_valid) begin
                            tmo_cnt_q <= '0;
                            if (smp_cnt_q == LAST_SMP) begin
                                // Result and strobe are registered on entry so
                                // they are visible for the whole DONE cycle.
                                state_q        <= DONE;
                                result_q       <= avg_d[CODE_W-1:0];
                                result_valid_q <= 1'b1;
                                acc_q          <= '0;
                                smp_cnt_q      <= '0;
                            end else begin
                                acc_q     <= acc_d;
                                smp_cnt_q <= smp_cnt_q + 1'b1;
                            end
                        end else if (tmo_cnt_q == TMO_LAST) begin
                            state_q       <= IDLE;
                            sensor_en_q   <= 1'b0;
                            busy_q        <= 1'b0;
                            timeout_err_q <= 1'b1;
                            tmo_cnt_q     <= '0;
                            smp_cnt_q     <= '0;
                            acc_q         <= '0;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
                    end
                    DONE: begin
                        if (cont) begin
                            // Sensor is already warm and in phase: no re-settle.
                            state_q   <= ACCUM;
                            tmo_cnt_q <= '0;
                        end else begin
                            state_q     <= IDLE;
                            sensor_en_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        sensor_en_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sensor_en    = sensor_en_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_temp_sense_seq.sv
// tb/tb_temp_sense_seq.sv - scoreboard bench for temp_sense_seq

module tb_temp_sense_seq;

    localparam int CODE_W = 12;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              cont;
    logic              abort;
    logic              meas_valid;
    logic [CODE_W-1:0] meas_code;
    logic              sensor_en;
    logic              busy;
    logic [CODE_W-1:0] result;
    logic              result_valid;
    logic              timeout_err;

    int                n_checks = 0;
    int                n_pass   = 0;
    int                rv_seen  = 0;
    logic [CODE_W-1:0] exp_q[$];
    logic [CODE_W-1:0] last_exp = '0;
    logic              watch_en = 1'b0;
    logic              en_dropped = 1'b0;

    always #5 clk = ~clk;

    temp_sense_seq #(
        .CODE_W        (CODE_W),
        .AVG_LOG2      (2),
        .SETTLE_CYCLES (16),
        .TIMEOUT_CYCLES(4095)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .cont        (cont),
        .abort       (abort),
        .meas_valid  (meas_valid),
        .meas_code   (meas_code),
        .sensor_en   (sensor_en),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Each result_valid cycle must match the oldest expected result.
    always @(negedge clk) begin
        if (result_valid) begin
            rv_seen++;
            if (exp_q.size() == 0) begin
                check("rv_unexpected", 32'd1, 32'd0);
            end else begin
                last_exp = exp_q.pop_front();
                check("result", 32'(result), 32'(last_exp));
            end
        end
        if (watch_en && !sensor_en) en_dropped = 1'b1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CODE_W-1:0] code);
        meas_valid = 1'b1;
        meas_code  = code;
        tick;
        meas_valid = 1'b0;
        tick;
    endtask

    task automatic start_conv;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Start, wait out SETTLE and feed the dropped partial sample: ends in ACCUM.
    task automatic begin_conv;
        start_conv;
        repeat (16) tick;
        send(12'd77);
    endtask

    task automatic conv4(input logic [CODE_W-1:0] a, input logic [CODE_W-1:0] b,
                         input logic [CODE_W-1:0] c, input logic [CODE_W-1:0] d,
                         input logic [CODE_W-1:0] exp);
        exp_q.push_back(exp);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    // A decoy code on the last SETTLE cycle and the partial sample on the first
    // DISCARD cycle: any change in SETTLE length shifts which codes are averaged.
    task automatic probe_conv(input bit extra_start, input logic [CODE_W-1:0] base,
                              input logic [CODE_W-1:0] exp);
        start_conv;
        check("en_after_start", 32'(sensor_en), 32'd1);
        check("busy_after_start", 32'(busy), 32'd1);
        repeat (3) tick;
        if (extra_start) begin
            start = 1'b1;
            tick;
            start = 1'b0;
        end else begin
            tick;
        end
        repeat (11) tick;
        meas_valid = 1'b1;
        meas_code  = 12'd4000;
        tick;
        meas_code  = 12'd999;
        tick;
        meas_valid = 1'b0;
        conv4(base, base + 12'd4, base + 12'd8, base + 12'd12, exp);
        check("en_off_after_done", 32'(sensor_en), 32'd0);
        check("busy_off_after_done", 32'(busy), 32'd0);
        check("result_held", 32'(result), 32'(exp));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rv_base;
        reset_n    = 1'b0;
        start      = 1'b0;
        cont       = 1'b0;
        abort      = 1'b0;
        meas_valid = 1'b0;
        meas_code  = '0;
        repeat (3) tick;
        check("rst_sensor_en", 32'(sensor_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;
        tick;

        // Single conversion: (1200+1204+1208+1212)/4 = 1206
        probe_conv(1'b0, 12'd1200, 12'd1206);
        check("single_rv_count", 32'(rv_seen), 32'd1);

        // Truncation: 4003 >> 2 = 1000
        begin_conv;
        conv4(12'd1000, 12'd1001, 12'd1001, 12'd1001, 12'd1000);

        // Start pulsed during SETTLE must not stretch the sequence
        probe_conv(1'b1, 12'd1100, 12'd1106);

        // Continuous mode: second conversion has no discard, enable stays up
        cont = 1'b1;
        begin_conv;
        watch_en = 1'b1;
        exp_q.push_back(12'd1300);
        repeat (4) send(12'd1300);
        exp_q.push_back(12'd1400);
        repeat (3) send(12'd1400);
        cont = 1'b0;
        send(12'd1400);
        watch_en = 1'b0;
        check("cont_en_never_dropped", 32'(en_dropped), 32'd0);
        check("cont_en_off_at_end", 32'(sensor_en), 32'd0);
        check("cont_results_out", 32'(exp_q.size()), 32'd0);

        // meas_valid on the expiry cycle is taken as a sample, no timeout
        begin_conv;
        exp_q.push_back(12'd2000);
        send(12'd2000);
        repeat (4093) tick;
        send(12'd2000);
        check("coincide_no_terr", 32'(timeout_err), 32'd0);
        check("coincide_busy", 32'(busy), 32'd1);
        send(12'd2000);
        send(12'd2000);
        check("coincide_done", 32'(exp_q.size()), 32'd0);

        // Timeout after 4095 silent cycles in ACCUM
        begin_conv;
        send(12'd1500);
        rv_base = rv_seen;
        repeat (4093) tick;
        check("tmo_not_early_busy", 32'(busy), 32'd1);
        check("tmo_not_early_terr", 32'(timeout_err), 32'd0);
        tick;
        check("tmo_terr", 32'(timeout_err), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_en", 32'(sensor_en), 32'd0);
        check("tmo_no_rv", 32'(rv_seen), 32'(rv_base));
        start_conv;
        check("start_clears_terr", 32'(timeout_err), 32'd0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_settle_busy", 32'(busy), 32'd0);

        // Abort after two samples
        begin_conv;
        send(12'd500);
        send(12'd600);
        rv_base = rv_seen;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_en", 32'(sensor_en), 32'd0);
        check("abort_result_kept", 32'(result), 32'(last_exp));
        check("abort_terr_kept", 32'(timeout_err), 32'd0);
        repeat (3) tick;
        check("abort_no_rv", 32'(rv_seen), 32'(rv_base));

        // Abort wins over start in IDLE
        abort = 1'b1;
        start = 1'b1;
        tick;
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_idle_busy", 32'(busy), 32'd0);
        check("abort_start_idle_en", 32'(sensor_en), 32'd0);

        // Reset mid-ACCUM, then a clean conversion: 3224/4 = 806
        begin_conv;
        send(12'd100);
        send(12'd200);
        reset_n = 1'b0;
        tick;
        check("mid_rst_en", 32'(sensor_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_rv", 32'(result_valid), 32'd0);
        check("mid_rst_terr", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;
        tick;
        begin_conv;
        conv4(12'd800, 12'd804, 12'd808, 12'd812, 12'd806);

        repeat (4) tick;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
